// File: rtl/vram_plane_ram.sv
`default_nettype none
// ============================================================================
// Module  : vram_plane_ram
// Brief   : Multi-plane video RAM. The CPU port supports masked replace and
//           OR/AND/XOR writes and has a clear engine. The video port reads
//           every plane of one address on each cycle.
// Rev     : 1.0  initial release
// ============================================================================
module vram_plane_ram #(
  parameter int                    ADDR_WIDTH  = 13,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    PLANES      = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        q,
  input  logic                         wr_n,
  input  logic                         ce_n,
  input  logic [PLANES-1:0]            wr_mask,
  input  logic [1:0]                   rd_plane,
  input  logic [1:0]                   wr_mode,
  input  logic [ADDR_WIDTH-1:0]        vaddr,
  output logic [PLANES*DATA_WIDTH-1:0] vdata,
  input  logic                         clr_start,
  input  logic [PLANES-1:0]            clr_mask,
  output logic                         clr_busy,
  output logic                         clr_done
);
  localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]             r_clr_cnt, w_clr_cnt_nxt;
  logic [PLANES-1:0]                 r_clr_mask, w_clr_mask_nxt;
  logic                              w_busy_nxt, w_done_nxt;

  logic [PLANES-1:0][DATA_WIDTH-1:0] w_mem_a, w_mem_v, w_fwd, w_rmw, r_pend_data;
  logic                              r_pend_valid;
  logic [ADDR_WIDTH-1:0]             r_pend_addr;
  logic [PLANES-1:0]                 r_pend_mask;
  logic                              w_cpu_wr, w_rep_wr, w_rmw_wr, w_clr_wr, w_pend_hit;
  logic [DATA_WIDTH-1:0]             w_rd_word, r_rdata;

  assign w_cpu_wr   = !reset && !ce_n && !wr_n && (r_state == S_IDLE);
  assign w_rep_wr   = w_cpu_wr && (wr_mode == 2'd0);
  assign w_rmw_wr   = w_cpu_wr && (wr_mode != 2'd0);
  assign w_clr_wr   = (r_state == S_CLEAR);
  assign w_pend_hit = r_pend_valid && (r_pend_addr == addr);

  function automatic logic [DATA_WIDTH-1:0] f_logic_op(input logic [1:0]            mode,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    case (mode)
      2'd1:    return a | b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  generate
    for (genvar p = 0; p < PLANES; p++) begin : g_plane
      logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

      // Later assignments win on a shared address: replace beats a pending commit, clear beats both
      always_ff @(posedge clk) begin
        if (r_pend_valid && r_pend_mask[p]) r_mem[r_pend_addr] <= r_pend_data[p];
        if (w_rep_wr && wr_mask[p])         r_mem[addr]        <= din;
        if (w_clr_wr && r_clr_mask[p])      r_mem[r_clr_cnt]   <= CLEAR_VALUE;
      end

      assign w_mem_a[p] = r_mem[addr];
      assign w_mem_v[p] = r_mem[vaddr];
      // The pending result is not in the array yet, so CPU reads and RMWs take it from the pipeline
      assign w_fwd[p]   = (w_pend_hit && r_pend_mask[p]) ? r_pend_data[p] : w_mem_a[p];
      assign w_rmw[p]   = f_logic_op(wr_mode, w_fwd[p], din);
    end
  endgenerate

  always_comb begin
    w_rd_word = '0;
    for (int p = 0; p < PLANES; p++) begin
      if (rd_plane == 2'(p)) w_rd_word = w_fwd[p];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata      <= '0;
      vdata        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_mask  <= '0;
      r_pend_data  <= '0;
    end else begin
      r_rdata      <= w_rd_word;
      vdata        <= w_mem_v;
      r_pend_valid <= w_rmw_wr;
      if (w_rmw_wr) begin
        r_pend_addr <= addr;
        r_pend_mask <= wr_mask;
        r_pend_data <= w_rmw;
      end
    end
  end

  assign q = ce_n ? '0 : r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_clr_mask <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_clr_mask <= w_clr_mask_nxt;
      clr_busy   <= w_busy_nxt;
      clr_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_clr_mask_nxt = r_clr_mask;
    w_busy_nxt     = clr_busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt    = S_CLEAR;
          w_clr_cnt_nxt  = '0;
          w_clr_mask_nxt = clr_mask;
          w_busy_nxt     = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_plane_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_plane_ram
// Brief   : Scoreboard testbench for vram_plane_ram.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vram_plane_ram;
  localparam int         AW    = 9;
  localparam int         DW    = 8;
  localparam int         NP    = 3;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] CV    = 8'hAA;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] q;
  logic          wr_n = 1'b1;
  logic          ce_n = 1'b1;
  logic [NP-1:0] wr_mask = '0;
  logic [1:0]    rd_plane = '0;
  logic [1:0]    wr_mode = '0;
  logic [AW-1:0] vaddr = '0;
  logic [NP*DW-1:0] vdata;
  logic          clr_start = 1'b0;
  logic [NP-1:0] clr_mask = '0;
  logic          clr_busy;
  logic          clr_done;

  vram_plane_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PLANES     (NP),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .din      (din),
    .q        (q),
    .wr_n     (wr_n),
    .ce_n     (ce_n),
    .wr_mask  (wr_mask),
    .rd_plane (rd_plane),
    .wr_mode  (wr_mode),
    .vaddr    (vaddr),
    .vdata    (vdata),
    .clr_start(clr_start),
    .clr_mask (clr_mask),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb_v[$];
  logic [7:0] model [NP][DEPTH];
  int         n_cmp = 0;
  int         n_err = 0;
  string      tag;

  task automatic check(input string t, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", t, act, exp);
    end
  endtask

  function automatic logic [7:0] op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      2'd0:    return b;
      2'd1:    return a | b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] model_row(input logic [AW-1:0] a);
    return {8'h00, model[2][a], model[1][a], model[0][a]};
  endfunction

  // Expectations are taken from the model before this cycle's write is applied
  task automatic tick(input bit chk_q, input bit chk_v);
    exp_t e;
    if (chk_q) begin
      e.tag = tag;
      e.val = '0;
      if (!ce_n && rd_plane < 2'(NP)) e.val = {24'h0, model[rd_plane][addr]};
      sb_q.push_back(e);
    end
    if (chk_v) begin
      e.tag = tag;
      e.val = model_row(vaddr);
      sb_v.push_back(e);
    end
    if (!ce_n && !wr_n) begin
      for (int p = 0; p < NP; p++)
        if (wr_mask[p]) model[p][addr] = op(wr_mode, model[p][addr], din);
    end
    @(posedge clk);
    #1;
    if (chk_q && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, {24'h0, q}, e.val);
    end
    if (chk_v && sb_v.size() > 0) begin
      e = sb_v.pop_front();
      check(e.tag, {8'h0, vdata}, e.val);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input logic [2:0] m,
                    input logic [1:0] mode);
    ce_n = 1'b0; wr_n = 1'b0; addr = a; din = d; wr_mask = m; wr_mode = mode;
    tick(1'b0, 1'b0);
    ce_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic rd(input string t, input logic [AW-1:0] a, input logic [1:0] pl, input logic ce);
    ce_n = ce; wr_n = 1'b1; addr = a; rd_plane = pl; tag = t;
    tick(1'b1, 1'b0);
    ce_n = 1'b1;
  endtask

  task automatic vrd(input string t, input logic [AW-1:0] a);
    vaddr = a; tag = t;
    tick(1'b0, 1'b1);
  endtask

  // Starts a clear, counts busy cycles, and tries one CPU write part-way through
  task automatic run_clear(input logic [2:0] m, input string t);
    int n;
    clr_mask = m; clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    check({t, " busy rises"}, 32'(clr_busy), 32'd1);
    n = 0;
    while (clr_busy && n < 4 * DEPTH) begin
      n++;
      if (n == 100) begin
        ce_n = 1'b0; wr_n = 1'b0; addr = 9'd5; din = 8'h77; wr_mask = 3'b111; wr_mode = 2'd0;
      end else begin
        ce_n = 1'b1; wr_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ce_n = 1'b1; wr_n = 1'b1;
    check({t, " busy cycles"}, 32'(n), 32'(DEPTH));
    check({t, " done pulse"}, 32'(clr_done), 32'd1);
    @(posedge clk);
    #1;
    check({t, " done width"}, 32'(clr_done), 32'd0);
    for (int a = 0; a < DEPTH; a++)
      for (int p = 0; p < NP; p++)
        if (m[p]) model[p][a] = CV;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done_seen;

    ce_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset q", {24'h0, q}, 32'h0);
    check("reset vdata", {8'h0, vdata}, 32'h0);
    check("reset busy", 32'(clr_busy), 32'd0);
    check("reset done", 32'(clr_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ce_n  = 1'b1;

    run_clear(3'b111, "clear all");

    wr(9'h010, 8'h33, 3'b010, 2'd0);
    wr(9'h010, 8'h5A, 3'b101, 2'd0);
    rd("rd p0", 9'h010, 2'd0, 1'b0);
    rd("rd p1", 9'h010, 2'd1, 1'b0);
    rd("rd p2", 9'h010, 2'd2, 1'b0);
    rd("rd ce_n high", 9'h010, 2'd0, 1'b1);
    rd("rd plane3", 9'h010, 2'd3, 1'b0);

    wr(9'h020, 8'h0F, 3'b010, 2'd0);
    wr(9'h020, 8'hF0, 3'b010, 2'd1);
    wr(9'h020, 8'hFF, 3'b010, 2'd3);
    rd("or-xor fwd", 9'h020, 2'd1, 1'b0);
    wr(9'h021, 8'hFF, 3'b010, 2'd0);
    wr(9'h021, 8'h3C, 3'b010, 2'd2);
    rd("and fwd", 9'h021, 2'd1, 1'b0);
    wr(9'h022, 8'h81, 3'b111, 2'd0);
    wr(9'h022, 8'h0F, 3'b111, 2'd3);
    wr(9'h022, 8'h3C, 3'b111, 2'd1);
    rd("xor-or fwd", 9'h022, 2'd2, 1'b0);
    vrd("rmw committed 0x20", 9'h020);
    vrd("rmw committed 0x22", 9'h022);

    wr(9'h100, 8'h11, 3'b001, 2'd0);
    wr(9'h100, 8'h22, 3'b010, 2'd0);
    wr(9'h100, 8'h33, 3'b100, 2'd0);
    vrd("vdata 0x100", 9'h100);
    vaddr = 9'h100; ce_n = 1'b0; wr_n = 1'b0; addr = 9'h100; din = 8'h44;
    wr_mask = 3'b111; wr_mode = 2'd0; tag = "vdata same-edge old";
    tick(1'b0, 1'b1);
    ce_n = 1'b1; wr_n = 1'b1;
    vrd("vdata new", 9'h100);

    run_clear(3'b010, "clear p1");
    for (int a = 0; a < DEPTH; a++) vrd($sformatf("scan 0x%0h", a), AW'(a));

    // An RMW accepted on the clear-start edge, then reset before anything commits
    ce_n = 1'b0; wr_n = 1'b0; addr = 9'h030; din = 8'hFF; wr_mask = 3'b001; wr_mode = 2'd3;
    clr_mask = 3'b111; clr_start = 1'b1;
    @(posedge clk);
    #1;
    ce_n = 1'b1; wr_n = 1'b1; clr_start = 1'b0;
    check("abort busy before", 32'(clr_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort busy after", 32'(clr_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (clr_done) done_seen = 1'b1;
    end
    check("abort no done", 32'(done_seen), 32'd0);
    @(negedge clk);
    vrd("abort 0x30 unchanged", 9'h030);
    vrd("abort 0x00 unchanged", 9'h000);
    rd("abort rd p0 0x30", 9'h030, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
